// File: rtl/inst_seq_ctrl_pkg.sv
// Shared types and helpers for the instruction sequencer: state encoding,
// default widths and the read-credit rule.
package inst_seq_ctrl_pkg;

  localparam int INST_WIDTH  = 16;
  localparam int INST_ADDR_W = 8;
  localparam int ITER_W      = 8;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_DRAIN = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_e;

  // Words buffered plus words in flight must stay within the 2-entry FIFO,
  // counting the slot freed by a pop in the same cycle.
  function automatic logic issue_ok(input logic [1:0] fifo_cnt,
                                    input logic       inflight,
                                    input logic       pop);
    logic [2:0] credits;
    credits = {1'b0, fifo_cnt} + {2'b00, inflight};
    return (credits - {2'b00, pop}) < 3'd2;
  endfunction

endpackage

// File: rtl/inst_skid_fifo.sv
// 2-entry FIFO with a registered head, so the consumer sees a flop output.
// Push and pop may coincide; flush empties it in one cycle.
module inst_skid_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = 2'd0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0)      head_d = din_i;
          else if (cnt_q == 2'd1) tail_d = din_i;
          if (cnt_q != 2'd2) cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          if (cnt_q != 2'd0) begin
            head_d = tail_q;
            cnt_d  = cnt_q - 2'd1;
          end
        end
        2'b11: begin
          // Simultaneous push/pop: the incoming word lands behind whatever stays.
          if (cnt_q == 2'd2) begin
            head_d = tail_q;
            tail_d = din_i;
          end else begin
            head_d = din_i;
            cnt_d  = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout_o  = head_q;
  assign valid_o = (cnt_q != 2'd0);
  assign count_o = cnt_q;

endmodule

// File: rtl/inst_seq_ctrl.sv
// Instruction sequencer: reads a program from the instruction ROM, loops it
// iter_num times and streams the words to the PE array over valid/ready.
module inst_seq_ctrl
  import inst_seq_ctrl_pkg::*;
#(
  parameter int IW = INST_WIDTH,
  parameter int AW = INST_ADDR_W,
  parameter int CW = ITER_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   prog_len,
  input  logic [CW-1:0] iter_num,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [2*IW-1:0] rom_data,
  output logic [2*IW-1:0] inst_out,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic          busy,
  output logic          done
);

  seq_state_e    state_q, state_d;
  logic [AW-1:0] base_q, base_d, addr_q, addr_d;
  logic [AW:0]   len_q, len_d, word_q, word_d;
  logic [CW-1:0] iter_q, iter_d;
  logic          inflight_q;

  logic [1:0] fifo_cnt;
  logic       pop, push, issue, last_word, last_iter;

  assign pop       = inst_valid & inst_ready;
  assign issue     = (state_q == SEQ_RUN) & ~abort & issue_ok(fifo_cnt, inflight_q, pop);
  // Gating the push drops a read that returns in the abort cycle.
  assign push      = inflight_q & ~abort;
  assign last_word = ((word_q + (AW+1)'(1)) == len_q);
  assign last_iter = (iter_q == CW'(1));

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    addr_d  = addr_q;
    word_d  = word_q;
    iter_d  = iter_q;
    unique case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          base_d = base_addr;
          len_d  = prog_len;
          addr_d = base_addr;
          word_d = '0;
          iter_d = iter_num;
          // An empty program passes through DRAIN so busy is seen for a cycle.
          state_d = (prog_len == '0 || iter_num == '0) ? SEQ_DRAIN : SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        if (issue) begin
          if (last_word) begin
            word_d = '0;
            addr_d = base_q;
            iter_d = iter_q - CW'(1);
            if (last_iter) state_d = SEQ_DRAIN;
          end else begin
            word_d = word_q + (AW+1)'(1);
            addr_d = addr_q + AW'(1);
          end
        end
      end
      SEQ_DRAIN: begin
        // Leave as the last buffered word is accepted so done follows it directly.
        if (!inflight_q && fifo_cnt == {1'b0, pop}) state_d = SEQ_DONE;
      end
      SEQ_DONE: state_d = SEQ_IDLE;
      default:  state_d = SEQ_IDLE;
    endcase
    if (abort) state_d = SEQ_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEQ_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      iter_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      iter_q     <= iter_d;
      inflight_q <= issue;
    end
  end

  inst_skid_fifo #(.W(2*IW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (abort),
    .push_i  (push),
    .din_i   (rom_data),
    .pop_i   (pop),
    .dout_o  (inst_out),
    .valid_o (inst_valid),
    .count_o (fifo_cnt)
  );

  assign rom_en   = issue;
  assign rom_addr = addr_q;
  assign busy     = (state_q == SEQ_RUN) | (state_q == SEQ_DRAIN);
  assign done     = (state_q == SEQ_DONE);

endmodule
